// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
// Multi-cycle shift-and-add unsigned multiplier controller that sits directly
// upstream of the 16-bit ALU. While running it drives the ALU's A/B/FunSel/WF
// inputs and reads ALUOut back combinationally in the same cycle. It contains
// no multiplier or adder of its own: every add (FunSel 5'h14) and every left
// shift (FunSel 5'h1B) goes through the ALU. The product is WIDTH x WIDTH ->
// 2*WIDTH bits, and the latency is fixed at 2*WIDTH+1 cycles.
//
// Optional feature macro: ALU_MUL_FLAGS_EN
//   defined   : AluWF is raised during the final ADD cycle only, so the ALU
//               latches Z/N/C/O for the last 16-bit add (Z=1 iff Product==0).
//   undefined : AluWF stays 0 and the ALU flags are never touched.
//
// Ports
//   Clock      in   1      system clock, rising edge
//   Reset      in   1      synchronous, active-high reset
//   Start      in   1      request, sampled only while idle
//   OpA        in   WIDTH  multiplicand, captured on an accepted Start
//   OpB        in   WIDTH  multiplier, captured on an accepted Start
//   Busy       out  1      high whenever the sequencer is not idle
//   Done       out  1      one-cycle pulse, Product valid
//   Product    out  16     result register (upper bits zero when WIDTH<8)
//   AluA       out  16     to ALU A
//   AluB       out  16     to ALU B
//   AluFunSel  out  5      to ALU FunSel
//   AluWF      out  1      to ALU WF (flag write enable)
//   AluOut     in   16     from ALU ALUOut, combinational in the same cycle
module alu_mul_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  output logic             Busy,
  output logic             Done,
  output logic [15:0]      Product,
  output logic [15:0]      AluA,
  output logic [15:0]      AluB,
  output logic [4:0]       AluFunSel,
  output logic             AluWF,
  input  logic [15:0]      AluOut
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [4:0] FUN_IDLE  = 5'h10;
  localparam logic [4:0] FUN_ADD   = 5'h14;
  localparam logic [4:0] FUN_SHIFT = 5'h1B;

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} stateType;

  stateType state;
  logic [15:0] m;
  logic [WIDTH-1:0] q;
  logic [15:0] p;
  logic [CW-1:0] cnt;

  // Sequencer: each multiplier bit takes an ADD cycle (accumulate M or 0 so
  // the latency never depends on the data) followed by a SHIFT cycle that
  // doubles M through the ALU and consumes the bit. Busy and Done are
  // registered together with the state so they change cleanly at the edge.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= IDLE;
      m     <= '0;
      q     <= '0;
      p     <= '0;
      cnt   <= '0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            m     <= 16'(OpA);
            q     <= OpB;
            p     <= '0;
            cnt   <= '0;
            state <= ADD;
            Busy  <= 1'b1;
          end else begin
            Busy <= 1'b0;
          end
        end
        ADD: begin
          p     <= AluOut;
          state <= SHIFT;
        end
        SHIFT: begin
          m   <= AluOut;
          q   <= q >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
            Done  <= 1'b1;
          end else begin
            state <= ADD;
          end
        end
        DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

  assign Product = p;

  // ALU-facing signals are a pure decode of the registered state, so the
  // ALU sees stable operands for the whole cycle and AluOut can be captured
  // at the next edge without a feedback loop.
  always_comb begin
    AluA      = '0;
    AluB      = '0;
    AluFunSel = FUN_IDLE;
    AluWF     = 1'b0;
    case (state)
      ADD: begin
        AluA      = p;
        AluB      = q[0] ? m : 16'h0000;
        AluFunSel = FUN_ADD;
`ifdef ALU_MUL_FLAGS_EN
        // Only the final add leaves the flags describing the full product.
        AluWF     = (cnt == LAST);
`else
        AluWF     = 1'b0;
`endif
      end
      SHIFT: begin
        AluA      = m;
        AluB      = '0;
        AluFunSel = FUN_SHIFT;
      end
      default: begin
        AluA      = '0;
        AluB      = '0;
        AluFunSel = FUN_IDLE;
      end
    endcase
  end

endmodule
